// File: rtl/flag_jump_stage_pkg.sv
// Shared constants and helpers for the flag/jump stage: jump bit positions,
// special jump codes and the branch counter saturation value.
package flag_jump_stage_pkg;

    localparam int DATA_WIDTH = 16;

    localparam int J_GT = 0;
    localparam int J_EQ = 1;
    localparam int J_LT = 2;

    localparam logic [2:0]  JMP_NEVER  = 3'b000;
    localparam logic [2:0]  JMP_ALWAYS = 3'b111;
    localparam logic [15:0] CNT_MAX    = 16'hFFFF;

    typedef logic [2:0] jump_t;

    // Branch decision from the three condition bits and the derived flags.
    function automatic logic jump_take(input jump_t jmp, input logic zr, input logic ng);
        return (jmp[J_LT] & ng) | (jmp[J_EQ] & zr) | (jmp[J_GT] & ~zr & ~ng);
    endfunction

endpackage

// File: rtl/flag_jump_stage_if.sv
// Valid/ready bus between the ALU side, the flag/jump stage and the PC stage.
interface flag_jump_stage_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] alu_out;
    logic [2:0]       jump;
    logic             flags_we;
    logic             out_valid;
    logic             out_ready;
    logic             pc_load;

    modport master (
        output in_valid, alu_out, jump, flags_we, out_ready,
        input  in_ready, out_valid, pc_load
    );

    modport slave (
        input  in_valid, alu_out, jump, flags_we, out_ready,
        output in_ready, out_valid, pc_load
    );
endinterface

// File: rtl/flag_jump_stage_nz16.sv
// Combinational nonzero detect: OR reduction of every bit of a WIDTH-bit word.
module nz16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data,
    output logic             nonzero
);
    logic [WIDTH-1:0] chain;

    assign chain[0] = data[0];

    genvar gi;
    generate
        for (gi = 1; gi < WIDTH; gi++) begin : g_or
            assign chain[gi] = chain[gi-1] | data[gi];
        end
    endgenerate

    assign nonzero = chain[WIDTH-1];
endmodule

// File: rtl/flag_jump_stage.sv
// Two-stage status/branch pipeline: derives zr/ng from the ALU result, commits
// the flags as an entry leaves S1, and presents pc_load to the PC stage.
module flag_jump_stage
    import flag_jump_stage_pkg::*;
#(
    parameter int WIDTH = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    flag_jump_stage_if.slave  bus,
    output logic              zr_q,
    output logic              ng_q,
    output logic [15:0]       taken_cnt
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    jump_t            s1_jump;
    logic             s1_we;
    logic             s2_valid;
    logic             s2_pc_load;

    logic nonzero;
    logic zr;
    logic ng;
    logic take;
    logic s2_adv;
    logic accept;
    logic consume;

    nz16 #(.WIDTH(WIDTH)) u_nz16 (
        .data    (s1_data),
        .nonzero (nonzero)
    );

    assign zr   = ~nonzero;
    assign ng   = s1_data[WIDTH-1];
    assign take = jump_take(s1_jump, zr, ng);

    assign s2_adv       = ~s2_valid | bus.out_ready;
    assign bus.in_ready = ~s1_valid | s2_adv;
    assign accept       = bus.in_valid & bus.in_ready;

    assign bus.out_valid = s2_valid;
    assign bus.pc_load   = s2_valid & s2_pc_load;
    assign consume       = s2_valid & bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_jump    <= JMP_NEVER;
            s1_we      <= 1'b0;
            s2_valid   <= 1'b0;
            s2_pc_load <= 1'b0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
            taken_cnt  <= '0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.alu_out;
                s1_jump  <= bus.jump;
                s1_we    <= bus.flags_we;
            end else if (s2_adv) begin
                s1_valid <= 1'b0;
            end

            // Flags are architectural at the S1->S2 move, independent of when the PC stage consumes.
            if (s2_adv) begin
                s2_valid   <= s1_valid;
                s2_pc_load <= s1_valid & take;
                if (s1_valid && s1_we) begin
                    zr_q <= zr;
                    ng_q <= ng;
                end
            end

            if (consume && s2_pc_load && (taken_cnt != CNT_MAX)) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
        end
    end
endmodule
